// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seven_seg_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_DRIVE
  } scan_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_scan_timer.sv
// Loadable down-counter that parks at zero and flags expiry while it sits there.
module scan_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit scan controller with blanking, frame-synchronous
// value update and leading-zero suppression.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         lzb,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [NIBBLE_W*N_DIGITS-1:0] load_value,
  output logic [N_DIGITS-1:0]          digit_sel,
  output logic [NIBBLE_W-1:0]          digit_data,
  output logic                         frame_done
);

  localparam int TIMER_W = $clog2(max_int(REFRESH_DIV, BLANK_CYCLES) + 1);
  localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

  localparam logic [TIMER_W-1:0] DRIVE_LOAD = TIMER_W'(REFRESH_DIV - 1);
  localparam logic [TIMER_W-1:0] BLANK_LOAD = TIMER_W'(HAS_BLANK ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(N_DIGITS - 1);

  scan_state_t                  state;
  logic [IDX_W-1:0]             idx;
  logic [NIBBLE_W*N_DIGITS-1:0] active;
  logic [NIBBLE_W*N_DIGITS-1:0] pending;
  logic                         pending_full;

  logic                         timer_expired;
  logic                         timer_load;
  logic [TIMER_W-1:0]           timer_val;

  logic                         load_fire;
  logic                         frame_end;
  logic                         commit;
  logic [NIBBLE_W*N_DIGITS-1:0] active_next;
  logic [N_DIGITS-1:0]          lz_mask;
  logic                         enter_blank;
  logic                         enter_drive;
  logic [IDX_W-1:0]             idx_next;
  logic [NIBBLE_W-1:0]          drive_nibble;

  scan_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (!enable),
    .load     (timer_load),
    .load_val (timer_val),
    .expired  (timer_expired)
  );

  assign load_fire = load_valid && load_ready;
  assign frame_end = enable && (state == S_DRIVE) && timer_expired && (idx == LAST_IDX);
  assign commit    = pending_full && (frame_end || (state == S_IDLE));

  // Slot contents are chosen from the value as it stands after this edge's
  // commit, so a new frame never starts on the stale value.
  assign active_next = commit ? pending : active;

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    logic upper_zero;
    lz_mask    = '0;
    upper_zero = 1'b1;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      upper_zero = upper_zero && (active_next[i*NIBBLE_W +: NIBBLE_W] == '0);
      lz_mask[i] = lzb && upper_zero;
    end
  end

  always_comb begin
    enter_blank = 1'b0;
    enter_drive = 1'b0;
    idx_next    = idx;
    if (enable) begin
      unique case (state)
        S_IDLE: begin
          idx_next = '0;
          if (HAS_BLANK) enter_blank = 1'b1;
          else           enter_drive = 1'b1;
        end
        S_BLANK: begin
          if (timer_expired) enter_drive = 1'b1;
        end
        S_DRIVE: begin
          if (timer_expired) begin
            idx_next = (idx == LAST_IDX) ? '0 : idx + 1'b1;
            if (HAS_BLANK) enter_blank = 1'b1;
            else           enter_drive = 1'b1;
          end
        end
        default: begin
          idx_next = '0;
        end
      endcase
    end
  end

  assign timer_load   = enter_blank || enter_drive;
  assign timer_val    = enter_drive ? DRIVE_LOAD : BLANK_LOAD;
  assign drive_nibble = active_next[int'(idx_next)*NIBBLE_W +: NIBBLE_W];

  // NOTE: the value buffers are ordinary flops, so they are reset with the
  // rest of the state; this is what discards a pending value on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      idx          <= '0;
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      load_ready   <= 1'b1;
      digit_sel    <= '0;
      digit_data   <= '0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= frame_end;

      if (load_fire) begin
        pending      <= load_value;
        pending_full <= 1'b1;
        load_ready   <= 1'b0;
      end else if (commit) begin
        active       <= pending;
        pending_full <= 1'b0;
        load_ready   <= 1'b1;
      end

      if (!enable) begin
        state      <= S_IDLE;
        idx        <= '0;
        digit_sel  <= '0;
        digit_data <= '0;
      end else if (enter_drive) begin
        state <= S_DRIVE;
        idx   <= idx_next;
        if (lz_mask[idx_next]) begin
          digit_sel  <= '0;
          digit_data <= '0;
        end else begin
          digit_sel  <= N_DIGITS'(1) << idx_next;
          digit_data <= drive_nibble;
        end
      end else if (enter_blank) begin
        state      <= S_BLANK;
        idx        <= idx_next;
        digit_sel  <= '0;
        digit_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomised and directed bench for seven_seg_scanner against a frame-position model.
module tb_seven_seg_scanner;

  localparam int N     = 4;
  localparam int R     = 4;
  localparam int B     = 1;
  localparam int SLOT  = B + R;
  localparam int FRAME = N * SLOT;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           enable = 1'b0;
  logic           lzb = 1'b0;
  logic           load_valid = 1'b0;
  logic [4*N-1:0] load_value = '0;
  logic           load_ready;
  logic [N-1:0]   digit_sel;
  logic [3:0]     digit_data;
  logic           frame_done;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .N_DIGITS     (N),
    .REFRESH_DIV  (R),
    .BLANK_CYCLES (B)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .lzb        (lzb),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .digit_sel  (digit_sel),
    .digit_data (digit_data),
    .frame_done (frame_done)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: a running flag plus the position within the frame; the display
  // content follows from position arithmetic and the committed value.
  bit             m_run   = 1'b0;
  int             m_pos   = 0;
  logic [4*N-1:0] m_act   = '0;
  logic [4*N-1:0] m_pend  = '0;
  bit             m_full  = 1'b0;
  bit             m_ready = 1'b1;
  logic [N-1:0]   m_sel   = '0;
  logic [3:0]     m_data  = '0;
  bit             m_fd    = 1'b0;
  bit             fd_valid = 1'b0;
  int             fd_last  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    bit             fire, boundary, commit, suppress;
    int             slot, off;
    logic [4*N-1:0] upper;
    if (reset) begin
      m_run = 0; m_pos = 0; m_act = '0; m_pend = '0; m_full = 0; m_ready = 1;
      m_sel = '0; m_data = '0; m_fd = 0; fd_valid = 0;
      return;
    end
    fire     = load_valid && m_ready;
    boundary = m_run && enable && (m_pos == FRAME - 1);
    commit   = m_full && (!m_run || boundary);
    m_fd     = boundary;
    if (fire) begin
      m_pend = load_value; m_full = 1; m_ready = 0;
    end else if (commit) begin
      m_act = m_pend; m_full = 0; m_ready = 1;
    end
    if (!enable) begin
      m_run = 0; m_pos = 0; m_sel = '0; m_data = '0; fd_valid = 0;
    end else begin
      m_pos = m_run ? (m_pos + 1) % FRAME : 0;
      m_run = 1;
      slot  = m_pos / SLOT;
      off   = m_pos % SLOT;
      if (off < B) begin
        m_sel = '0; m_data = '0;
      end else if (off == B) begin
        upper    = m_act >> (4 * slot);
        suppress = lzb && (slot > 0) && (upper == '0);
        m_sel    = suppress ? '0 : N'(1 << slot);
        m_data   = suppress ? 4'h0 : upper[3:0];
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check("digit_sel", 32'(digit_sel), 32'(m_sel));
    check("digit_data", 32'(digit_data), 32'(m_data));
    check("frame_done", 32'(frame_done), 32'(m_fd));
    check("load_ready", 32'(load_ready), 32'(m_ready));
    if (frame_done === 1'b1) begin
      if (fd_valid) check("fd_period", 32'(cyc - fd_last), 32'(FRAME));
      fd_last  = cyc;
      fd_valid = 1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Offer a value and hold it until the model says it was taken.
  task automatic load(input logic [4*N-1:0] v, input int budget);
    bit took = 0;
    load_valid = 1; load_value = v;
    for (int i = 0; i < budget && !took; i++) begin
      took = m_ready;
      cycle();
    end
    if (!took) check("load_timeout", 32'(0), 32'(1));
    load_valid = 0;
  endtask

  task automatic wait_pos(input int pos, input int budget);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      cycle();
      hit = m_run && (m_pos == pos);
    end
    if (!hit) check("wait_pos_timeout", 32'(0), 32'(1));
  endtask

  function automatic logic [4*N-1:0] rand_value();
    logic [4*N-1:0] v = '0;
    for (int i = 0; i < N; i++)
      if ($urandom_range(0, 1) == 1) v[4*i +: 4] = 4'($urandom_range(0, 15));
    return v;
  endfunction

  initial begin
    bit took;

    // Reset state
    reset = 1;
    run(2);
    check("rst_sel", 32'(digit_sel), 32'(0));
    check("rst_ready", 32'(load_ready), 32'(1));
    reset = 0;

    // 1: value committed while idle, then plain scanning
    load(16'h1234, 4);
    run(2);
    enable = 1;
    cycle();
    check("s1_first_blank", 32'(digit_sel), 32'(0));
    cycle();
    check("s1_d0_sel", 32'(digit_sel), 32'(1));
    check("s1_d0_data", 32'(digit_data), 32'(4));
    run(2 * FRAME);

    // 2: leading-zero blanking on and off
    lzb = 1;
    load(16'h0045, 4);
    run(2 * FRAME + 2);
    lzb = 0;
    run(2 * FRAME);

    // 3: all-zero value only lights digit 0
    lzb = 1;
    load(16'h0000, 4);
    run(2 * FRAME + 2);
    lzb = 0;

    // 4: back-to-back loads, second held until the pending buffer drains
    wait_pos(7, 2 * FRAME);
    load(16'h1111, 4);
    load_valid = 1; load_value = 16'h2222;
    took = 0;
    for (int i = 0; i < 3 * FRAME && !took; i++) begin
      if (load_ready === 1'b1) begin
        took = 1;
        check("s4_ready_with_fd", 32'(frame_done), 32'(1));
      end
      cycle();
    end
    if (!took) check("s4_second_load", 32'(0), 32'(1));
    load_valid = 0;
    run(2 * FRAME + 2);

    // 5: enable dropped mid drive of digit 2
    wait_pos(2 * SLOT + B + 1, 2 * FRAME);
    enable = 0;
    cycle();
    check("s5_off_sel", 32'(digit_sel), 32'(0));
    check("s5_off_fd", 32'(frame_done), 32'(0));
    run(5);
    enable = 1;
    cycle();
    check("s5_restart_blank", 32'(digit_sel), 32'(0));
    run(FRAME + 5);

    // 6: reset while a value is pending
    wait_pos(3, 2 * FRAME);
    load(16'hBEEF, 4);
    run(2);
    reset = 1;
    cycle();
    check("s6_ready", 32'(load_ready), 32'(1));
    check("s6_sel", 32'(digit_sel), 32'(0));
    reset = 0;
    run(2 * FRAME);

    // Random phase
    for (int i = 0; i < 800; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      if (!enable && $urandom_range(0, 7) == 0) enable = 1;
      if ($urandom_range(0, 24) == 0) lzb = ~lzb;
      load_valid = ($urandom_range(0, 7) == 0);
      load_value = rand_value();
      cycle();
    end
    reset = 0; load_valid = 0;
    run(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
